// File: rtl/div_result_bcd.sv
// div_result_bcd
//   Captures the divider's 16-bit quotient and remainder on the rising edge of
//   done_in. It converts each value serially to packed BCD using shift-add-3
//   (double-dabble), then presents both digit sets with a valid/ready handshake.
//
// Ports
//   clock         system clock, rising edge
//   reset_n       synchronous, active-low reset
//   done_in       divider done level; only its rising edge triggers a capture
//   quotient_in   divider quotient, sampled at the capture edge only
//   remainder_in  divider remainder, sampled at the capture edge only
//   out_ready     consumer ready
//   out_valid     q_bcd/r_bcd hold a complete, new result
//   q_bcd         quotient in packed BCD, digit 0 in bits [3:0]
//   r_bcd         remainder in packed BCD
//   busy          conversion in progress (CONV_Q or CONV_R)
//   overrun       sticky; a done edge arrived while not IDLE and was dropped
//   state_dbg     current FSM state (IDLE=0, CONV_Q=1, CONV_R=2, VALID=3)
//
// Handshake: a result transfers on any rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_valid, q_bcd and r_bcd are held stable.
module div_result_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                done_in,
  input  logic [WIDTH-1:0]    quotient_in,
  input  logic [WIDTH-1:0]    remainder_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd,
  output logic                busy,
  output logic                overrun,
  output logic [1:0]          state_dbg
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_R = 2'd2,
    VALID  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_done_prev;
  logic [WIDTH-1:0]   r_q_bin;
  logic [WIDTH-1:0]   r_r_bin;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_q_bcd;
  logic [ACC_W-1:0]   r_r_bcd;
  logic               r_busy;
  logic               r_overrun;

  logic               w_done_rise;
  logic               w_shift_in;
  logic               w_last_iter;
  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_acc_next;

  assign w_done_rise = done_in & ~r_done_prev;
  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

  // The binary MSB fed into the accumulator comes from whichever value is
  // currently being converted.
  assign w_shift_in = (r_state == CONV_R) ? r_r_bin[WIDTH-1] : r_q_bin[WIDTH-1];

  // Add 3 to every digit that is 5 or more, so that after the left shift the
  // digit carries correctly into the next one. A digit is at most 9 here,
  // so the result stays at 12 or less and fits in the 4-bit digit.
  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_acc_next = {w_adj[ACC_W-2:0], w_shift_in};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_done_prev <= 1'b0;
      r_q_bin     <= '0;
      r_r_bin     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_q_bcd     <= '0;
      r_r_bcd     <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done_prev <= done_in;

      // A done edge is captured only in IDLE. In any other state it is
      // dropped and recorded. This includes VALID while the handshake is
      // completing on the same edge.
      if (w_done_rise && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_done_rise) begin
            r_q_bin <= quotient_in;
            r_r_bin <= remainder_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV_Q;
          end
        end

        CONV_Q: begin
          r_q_bin <= {r_q_bin[WIDTH-2:0], 1'b0};
          if (w_last_iter) begin
            r_q_bcd <= w_acc_next;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= CONV_R;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end

        CONV_R: begin
          r_r_bin <= {r_r_bin[WIDTH-2:0], 1'b0};
          if (w_last_iter) begin
            r_r_bcd     <= w_acc_next;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= VALID;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end

        VALID: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign q_bcd     = r_q_bcd;
  assign r_bcd     = r_r_bcd;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_div_result_bcd.sv
module tb_div_result_bcd;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                clock;
  logic                reset_n;
  logic                done_in;
  logic [WIDTH-1:0]    quotient_in;
  logic [WIDTH-1:0]    remainder_in;
  logic                out_ready;
  logic                out_valid;
  logic [4*DIGITS-1:0] q_bcd;
  logic [4*DIGITS-1:0] r_bcd;
  logic                busy;
  logic                overrun;
  logic [1:0]          state_dbg;

  int n_vec;
  int n_err;

  div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .done_in      (done_in),
    .quotient_in  (quotient_in),
    .remainder_in (remainder_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .q_bcd        (q_bcd),
    .r_bcd        (r_bcd),
    .busy         (busy),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Raises done_in at a negedge; the next posedge is the capture edge.
  // k counts negedges after that capture edge, so the state after edge
  // Ej is seen at k = j+1. Busy should be seen for k = 1..32 and out_valid
  // first at k = 33. The inputs are scrambled after capture, so they must
  // not affect the result.
  task automatic run_conv(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                          input bit hold, output int busy_n, output int valid_k);
    @(negedge clock);
    quotient_in  = q;
    remainder_in = r;
    done_in      = 1'b1;
    busy_n  = 0;
    valid_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (!hold) done_in = 1'b0;
      quotient_in  = ~q;
      remainder_in = ~r;
      if (busy) busy_n++;
      if (out_valid) begin
        valid_k = k;
        break;
      end
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    check_eq({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_hs_state"}, 32'(state_dbg), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int bn;
    int vk;
    int cnt;
    bit stable;
    logic [4*DIGITS-1:0] hold_q;
    logic [4*DIGITS-1:0] hold_r;

    n_vec        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    done_in      = 1'b0;
    quotient_in  = '0;
    remainder_in = '0;
    out_ready    = 1'b0;

    // 1: reset state, then 38/0
    do_reset();
    @(negedge clock);
    check_eq("rst_valid",   32'(out_valid), 32'd0);
    check_eq("rst_busy",    32'(busy),      32'd0);
    check_eq("rst_overrun", 32'(overrun),   32'd0);
    check_eq("rst_q",       32'(q_bcd),     32'd0);
    check_eq("rst_r",       32'(r_bcd),     32'd0);
    check_eq("rst_state",   32'(state_dbg), 32'd0);

    run_conv(16'd38, 16'd0, 1'b0, bn, vk);
    check_eq("t1_busy_cycles", 32'(bn), 32'd32);
    check_eq("t1_latency",     32'(vk), 32'd33);
    check_eq("t1_q", 32'(q_bcd), 32'h00038);
    check_eq("t1_r", 32'(r_bcd), 32'h00000);
    check_eq("t1_busy_in_valid", 32'(busy), 32'd0);
    check_eq("t1_state_valid", 32'(state_dbg), 32'd3);
    handshake("t1");

    // 2: full-scale and zero
    run_conv(16'd65535, 16'd9999, 1'b0, bn, vk);
    check_eq("t2_latency", 32'(vk), 32'd33);
    check_eq("t2_q", 32'(q_bcd), 32'h65535);
    check_eq("t2_r", 32'(r_bcd), 32'h09999);
    handshake("t2a");
    run_conv(16'd0, 16'd0, 1'b0, bn, vk);
    check_eq("t2z_latency", 32'(vk), 32'd33);
    check_eq("t2z_q", 32'(q_bcd), 32'h00000);
    check_eq("t2z_r", 32'(r_bcd), 32'h00000);
    check_eq("t2z_valid", 32'(out_valid), 32'd1);
    handshake("t2z");

    // 3: backpressure for 20 cycles
    run_conv(16'd1234, 16'd567, 1'b0, bn, vk);
    check_eq("t3_q", 32'(q_bcd), 32'h01234);
    check_eq("t3_r", 32'(r_bcd), 32'h00567);
    hold_q = q_bcd;
    hold_r = r_bcd;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!out_valid || q_bcd !== hold_q || r_bcd !== hold_r) stable = 1'b0;
    end
    check_eq("t3_stable", 32'(stable), 32'd1);
    handshake("t3");
    @(negedge clock);
    check_eq("t3_valid_stays_low", 32'(out_valid), 32'd0);
    check_eq("t3_q_kept", 32'(q_bcd), 32'h01234);
    check_eq("t3_r_kept", 32'(r_bcd), 32'h00567);

    // 4: done_in held high for 100 cycles with out_ready high
    out_ready = 1'b1;
    @(negedge clock);
    quotient_in  = 16'd250;
    remainder_in = 16'd12;
    done_in      = 1'b1;
    cnt = 0;
    bn  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (out_valid) cnt++;
      if (busy) bn++;
    end
    done_in   = 1'b0;
    out_ready = 1'b0;
    check_eq("t4_valid_pulses", 32'(cnt), 32'd1);
    check_eq("t4_busy_cycles",  32'(bn),  32'd32);
    check_eq("t4_overrun", 32'(overrun), 32'd0);
    check_eq("t4_q", 32'(q_bcd), 32'h00250);
    check_eq("t4_r", 32'(r_bcd), 32'h00012);

    // 5: done edges during CONV_R and during VALID (same edge as handshake)
    @(negedge clock);
    quotient_in  = 16'd7;
    remainder_in = 16'd3;
    done_in      = 1'b1;
    @(negedge clock);
    done_in = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clock);
    check_eq("t5_in_conv_r", 32'(state_dbg), 32'd2);
    quotient_in  = 16'd99;
    remainder_in = 16'd98;
    done_in      = 1'b1;
    @(negedge clock);
    done_in = 1'b0;
    check_eq("t5_overrun_conv_r", 32'(overrun), 32'd1);
    vk = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (out_valid) begin
        vk = k;
        break;
      end
    end
    check_eq("t5_completed", 32'(vk != 0), 32'd1);
    check_eq("t5_q", 32'(q_bcd), 32'h00007);
    check_eq("t5_r", 32'(r_bcd), 32'h00003);
    done_in   = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    done_in   = 1'b0;
    out_ready = 1'b0;
    check_eq("t5_same_edge_state",   32'(state_dbg), 32'd0);
    check_eq("t5_same_edge_valid",   32'(out_valid), 32'd0);
    check_eq("t5_overrun_sticky",    32'(overrun),   32'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid || busy) cnt++;
    end
    check_eq("t5_no_extra_conv", 32'(cnt), 32'd0);
    check_eq("t5_overrun_held", 32'(overrun), 32'd1);
    check_eq("t5_q_kept", 32'(q_bcd), 32'h00007);

    // 6: reset mid-conversion, then fresh conversion
    @(negedge clock);
    quotient_in  = 16'd999;
    remainder_in = 16'd888;
    done_in      = 1'b1;
    @(negedge clock);
    done_in = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_eq("t6_busy",    32'(busy),      32'd0);
    check_eq("t6_valid",   32'(out_valid), 32'd0);
    check_eq("t6_q",       32'(q_bcd),     32'd0);
    check_eq("t6_r",       32'(r_bcd),     32'd0);
    check_eq("t6_overrun", 32'(overrun),   32'd0);
    check_eq("t6_state",   32'(state_dbg), 32'd0);
    run_conv(16'd123, 16'd45, 1'b0, bn, vk);
    check_eq("t6_latency", 32'(vk), 32'd33);
    check_eq("t6_fresh_q", 32'(q_bcd), 32'h00123);
    check_eq("t6_fresh_r", 32'(r_bcd), 32'h00045);
    handshake("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Sits directly downstream of the repeated-subtraction divider datapath and control pair.
- Captures the 16-bit quotient and remainder when the divider's done rises.
- Converts each value serially to packed BCD with shift-add-3 (double-dabble).
- Presents both digit sets to the display/readout stage with a valid/ready handshake.

Parameters:
WIDTH, 16, bit width of quotient and remainder inputs
DIGITS, 5, BCD digits per result; must satisfy 10^DIGITS > 2^WIDTH-1

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
done_in  input  1  divider done flag (level); capture is triggered by its rising edge
quotient_in  input  WIDTH  divider quotient, valid while done_in high
remainder_in  input  WIDTH  divider remainder, valid while done_in high
out_ready  input  1  consumer accepts result when high with out_valid
out_valid  output  1  q_bcd/r_bcd hold a complete, new result
q_bcd  output  4*DIGITS  quotient in packed BCD, digit 0 in bits [3:0]
r_bcd  output  4*DIGITS  remainder in packed BCD
busy  output  1  conversion in progress (CONV_Q or CONV_R)
overrun  output  1  sticky: a done edge arrived while not IDLE

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clock).
- Reset: state=IDLE; out_valid, busy, overrun, q_bcd, r_bcd, done_prev and all internal registers = 0.
- Edge detect: done_prev <= done_in every cycle. done_rise = done_in & ~done_prev.
  - done_in held high for many cycles produces exactly one done_rise.
- States: IDLE, CONV_Q, CONV_R, VALID.
- IDLE: on done_rise, capture quotient_in/remainder_in into shift registers, clear BCD accumulator and 5-bit iteration counter, go to CONV_Q. This is capture edge E0.
- CONV_Q: one double-dabble iteration per clock.
  - Each BCD nibble >=5 gets +3 (combinational, all nibbles in parallel).
  - The accumulator then shifts left 1, taking in the binary register MSB; the binary register shifts left 1.
  - After WIDTH iterations (edge E16), store the accumulator in q_bcd, clear the accumulator, reset the counter, go to CONV_R.
- CONV_R: same algorithm on the remainder. At edge E32, store the result in r_bcd, set out_valid=1, go to VALID.
- Latency: out_valid is high in the cycle after E32, i.e. 2*WIDTH cycles after the capture edge.
- busy = 1 exactly in CONV_Q and CONV_R.
- VALID: q_bcd, r_bcd and out_valid are held stable while out_ready=0.
  - out_valid & out_ready at an edge: out_valid<=0, go to IDLE.
  - q_bcd/r_bcd keep their last value until the next conversion stores over them.
  - q_bcd is not updated until the whole new conversion reaches E16.
- Overrun: done_rise in CONV_Q, CONV_R or VALID is dropped (not queued) and sets overrun=1. overrun clears only on reset.
  - Same-edge case: done_rise in VALID with out_ready=1 is also dropped and flagged, because capture happens only in IDLE.
- Reset mid-conversion (any state) overrides everything: all outputs and state return to reset values at that edge, and no partial result appears.
- Inputs are sampled only at the capture edge. Later changes on quotient_in/remainder_in have no effect.
- Arithmetic is unsigned; the accumulator is 4*DIGITS bits wide, and the +3 correction never overflows a nibble.

Test Plan:
1. Reset, then done_in 0->1 with quotient_in=38, remainder_in=0 -> busy high for 32 cycles; out_valid high 32 cycles after capture; q_bcd=20'h00038, r_bcd=20'h00000; out_ready=1 -> out_valid low next cycle, state IDLE.
2. quotient_in=65535, remainder_in=9999 -> q_bcd=20'h65535, r_bcd=20'h09999. Repeat with 0/0 -> both 20'h00000 and out_valid still asserted.
3. Backpressure: out_ready held 0 for 20 cycles after out_valid -> out_valid and digits stable for all 20 cycles; out_ready=1 -> single-cycle handshake completes.
4. done_in held high 100 cycles, out_ready=1 -> exactly one conversion and one out_valid pulse; overrun stays 0.
5. Second done rise during CONV_R, then during VALID -> overrun=1 and stays 1; in-flight result (quotient=7, remainder=3 -> 20'h00007/20'h00003) completes unchanged; no extra out_valid.
6. reset_n=0 for one cycle at capture+10 -> busy=0, out_valid=0, q_bcd=r_bcd=0, overrun=0. A fresh done rise with 123/45 -> 20'h00123/20'h00045.
